// File: rtl/spi_xfer_sequencer.sv
// Register-bank driven SPI master (mode 0): reads a control word, shifts n_end+1 bytes out/in,
// writes received bytes back to the bank and finally clears the send bit in the control word.
module spi_xfer_sequencer #(
    parameter int N   = 5,
    parameter int DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   rd_data,
    output logic [N:0]    addr,
    output logic          wr,
    output logic [7:0]    wr_data,
    output logic          hold,
    output logic          busy,
    output logic          done,
    output logic          sclk,
    output logic          mosi,
    input  logic          miso,
    output logic          cs_n
);
    localparam int IDXW = N + 1;
    localparam int CW   = (DIV > 1) ? $clog2(2 * DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_FETCH,
        S_SHIFT,
        S_WRBACK,
        S_CLRCTL
    } state_t;

    state_t          state;
    logic [7:0]      cfg;
    logic [N:0]      idx;
    logic [N:0]      last_idx;
    logic [7:0]      tx_sr;
    logic [7:0]      rx_sr;
    logic [CW-1:0]   cnt;
    logic [2:0]      bitn;

    logic [N:0]      last_c;
    logic [7:0]      tx_c;
    logic            unused_rd;

    assign unused_rd = ^{rd_data[31:8], cfg[0]};

    // Data entries are 1..N, so the last byte index can never go beyond N-1.
    always_comb begin
        if (32'(rd_data[7:3]) > 32'(N - 1))
            last_c = IDXW'(N - 1);
        else
            last_c = IDXW'(rd_data[7:3]);
    end

    always_comb begin
        if (cfg[1])
            tx_c = 8'hFF;
        else if (cfg[2])
            tx_c = 8'h00;
        else
            tx_c = rd_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cfg      <= '0;
            idx      <= '0;
            last_idx <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cnt      <= '0;
            bitn     <= '0;
            addr     <= '0;
            wr       <= 1'b0;
            wr_data  <= '0;
            hold     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            wr      <= 1'b0;
            wr_data <= '0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CFG;
                        hold  <= 1'b1;
                        busy  <= 1'b1;
                        addr  <= '0;
                    end
                end
                S_CFG: begin
                    cfg      <= rd_data[7:0];
                    idx      <= '0;
                    last_idx <= last_c;
                    if (rd_data[0]) begin
                        state <= S_FETCH;
                        addr  <= IDXW'(1);
                    end else begin
                        state <= S_IDLE;
                        hold  <= 1'b0;
                        busy  <= 1'b0;
                        addr  <= '0;
                    end
                end
                S_FETCH: begin
                    state <= S_SHIFT;
                    tx_sr <= tx_c;
                    mosi  <= tx_c[7];
                    cs_n  <= 1'b0;
                    cnt   <= '0;
                    bitn  <= '0;
                    sclk  <= 1'b0;
                end
                S_SHIFT: begin
                    if (cnt == CW'(DIV - 1)) begin
                        // Rising SCLK: capture the slave's bit at the same instant it sees ours.
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[6:0], miso};
                        cnt   <= cnt + CW'(1);
                    end else if (cnt == CW'(2 * DIV - 1)) begin
                        sclk <= 1'b0;
                        cnt  <= '0;
                        if (bitn == 3'd7) begin
                            state   <= S_WRBACK;
                            wr      <= 1'b1;
                            wr_data <= rx_sr;
                            mosi    <= 1'b0;
                        end else begin
                            bitn  <= bitn + 3'd1;
                            tx_sr <= {tx_sr[6:0], 1'b0};
                            mosi  <= tx_sr[6];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WRBACK: begin
                    if (idx == last_idx) begin
                        state   <= S_CLRCTL;
                        addr    <= '0;
                        wr      <= 1'b1;
                        wr_data <= {cfg[7:1], 1'b0};
                    end else begin
                        state <= S_FETCH;
                        idx   <= idx + IDXW'(1);
                        addr  <= idx + IDXW'(2);
                    end
                end
                S_CLRCTL: begin
                    state <= S_IDLE;
                    hold  <= 1'b0;
                    busy  <= 1'b0;
                    cs_n  <= 1'b1;
                    done  <= 1'b1;
                    addr  <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: a bank model, scoreboard queues for writes and MOSI bits,
// and directed frames with hand-computed timing.
module tb_spi_xfer_sequencer;
    localparam int N   = 5;
    localparam int DIV = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   rd_data;
    logic [N:0]    addr;
    logic          wr;
    logic [7:0]    wr_data;
    logic          hold;
    logic          busy;
    logic          done;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          cs_n;

    logic          force_one;
    logic          bit_chk;
    logic          tb_we;
    logic [N:0]    tb_a;
    logic [31:0]   tb_d;
    logic [31:0]   bank [0:(2**(N+1))-1];

    int            checks = 0;
    int            failures = 0;
    int            cs_low_cnt = 0;
    int            done_cnt = 0;
    logic          sclk_q = 1'b0;
    int            exp_wr[$];
    logic          exp_bits[$];

    always #5 clk = ~clk;

    assign miso    = force_one ? 1'b1 : mosi;
    assign rd_data = bank[addr];

    spi_xfer_sequencer #(.N(N), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_data(rd_data),
        .addr(addr), .wr(wr), .wr_data(wr_data), .hold(hold),
        .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    always @(posedge clk) begin
        if (tb_we)
            bank[tb_a] <= tb_d;
        else if (wr)
            bank[addr] <= {24'h0, wr_data};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every bank write and every rising SCLK is matched against the scoreboard.
    always @(negedge clk) begin
        if (wr) begin
            if (exp_wr.size() == 0)
                check("unexpected_wr", 32'({addr, wr_data}), 32'hFFFF_FFFF);
            else
                check("bank_wr", 32'({addr, wr_data}), 32'(exp_wr.pop_front()));
        end
        if (bit_chk && sclk && !sclk_q) begin
            if (exp_bits.size() == 0)
                check("unexpected_bit", 32'(mosi), 32'hFFFF_FFFF);
            else
                check("mosi_bit", 32'(mosi), 32'(exp_bits.pop_front()));
        end
        if (!rst && !cs_n) cs_low_cnt++;
        if (done) done_cnt++;
        sclk_q = sclk;
    end

    task automatic set_bank(input int a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_a  = (N+1)'(a);
        tb_d  = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic push_wr(input int a, input int d);
        exp_wr.push_back((a << 8) | d);
    endtask

    task automatic push_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
    endtask

    // Runs one frame; cyc counts cycles from CFG through the done cycle inclusive.
    task automatic run_frame(input string tag, input int exp_len, input int exp_cs, input int busy_at);
        int cyc;
        cs_low_cnt = 0;
        done_cnt   = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 1000) begin
            start = (cyc == busy_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_len"}, 32'(cyc), 32'(exp_len));
        repeat (6) @(negedge clk);
        check({tag, "_cs_low"}, 32'(cs_low_cnt), 32'(exp_cs));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
        check({tag, "_idle"}, 32'({hold, busy, cs_n, sclk}), 32'b0010);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; force_one = 1'b0; bit_chk = 1'b1;
        tb_we = 1'b0; tb_a = '0; tb_d = '0;
        for (int i = 0; i < 2**(N+1); i++) bank[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({cs_n, sclk, mosi, hold, wr, wr_data, addr, busy, done}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 1'b0, 1'b0}));
        rst = 1'b0;

        // Two-byte loopback: 72 cycles counting the start cycle, 71 from CFG.
        set_bank(1, 32'hA5); set_bank(2, 32'h3C); set_bank(0, 32'h09);
        push_bits(8'hA5); push_bits(8'h3C);
        push_wr(1, 8'hA5); push_wr(2, 8'h3C); push_wr(0, 8'h08);
        run_frame("loop2", 71, 68, 0);
        check("loop2_bank0", bank[0], 32'h08);

        // all_zeros with MISO stuck high.
        force_one = 1'b1;
        set_bank(1, 32'h11); set_bank(0, 32'h05);
        push_bits(8'h00);
        push_wr(1, 8'hFF); push_wr(0, 8'h04);
        run_frame("zeros", 37, 34, 0);
        force_one = 1'b0;

        // send=0: one CFG cycle then straight back to IDLE.
        set_bank(0, 32'h08);
        cs_low_cnt = 0; done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("nosend_cfg", 32'({hold, busy, addr}), 32'({1'b1, 1'b1, 6'h00}));
        @(negedge clk);
        check("nosend_idle", 32'({hold, busy}), 32'b00);
        repeat (10) @(negedge clk);
        check("nosend_cs", 32'(cs_low_cnt), 32'd0);
        check("nosend_done", 32'(done_cnt), 32'd0);
        check("nosend_bank0", bank[0], 32'h08);

        // n_end=31 clamps to 4: five all-ones bytes to addresses 1..5.
        set_bank(0, 32'hFB);
        for (int i = 1; i <= 5; i++) begin
            push_bits(8'hFF);
            push_wr(i, 8'hFF);
        end
        push_wr(0, 8'hFA);
        run_frame("clamp", 173, 170, 0);

        // Reset during bit 3 of byte 0 (SHIFT cycles 3..34, bit 3 is cycles 15..18).
        set_bank(1, 32'hA5); set_bank(2, 32'h3C); set_bank(0, 32'h09);
        bit_chk = 1'b0;
        done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs", 32'({cs_n, sclk, hold, busy}), 32'b1000);
        check("midrst_done", 32'(done_cnt), 32'd0);
        bit_chk = 1'b1;
        push_bits(8'hA5); push_bits(8'h3C);
        push_wr(1, 8'hA5); push_wr(2, 8'h3C); push_wr(0, 8'h08);
        run_frame("after_rst", 71, 68, 0);

        // Start pulse in the middle of SHIFT is ignored.
        set_bank(1, 32'h5A); set_bank(2, 32'hC3); set_bank(0, 32'h09);
        push_bits(8'h5A); push_bits(8'hC3);
        push_wr(1, 8'h5A); push_wr(2, 8'hC3); push_wr(0, 8'h08);
        run_frame("busy_start", 71, 68, 20);
        repeat (40) @(negedge clk);
        check("busy_start_quiet", 32'({busy, 8'(done_cnt)}), 32'({1'b0, 8'd1}));

        // rst wins over start in the same cycle.
        set_bank(0, 32'h09);
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_priority", 32'({busy, hold, cs_n}), 32'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameter N, default 5, register-bank address MSB; the bank holds entries 0..N.
REQ-002 SHALL have parameter DIV, default 2, clk cycles per SCLK half-period; legal range is DIV >= 1.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to run one frame.
REQ-006 SHALL have port rd_data, input, 32, combinational read data of bank[addr].
REQ-007 SHALL have port addr, output, N+1, bank address driven while hold=1.
REQ-008 SHALL have port wr, output, 1, one-cycle bank write strobe.
REQ-009 SHALL have port wr_data, output, 8, write byte; the bank zero-extends it.
REQ-010 SHALL have port hold, output, 1, bank-port ownership; 1 = this block owns the bank.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle frame-complete pulse.
REQ-013 SHALL have port sclk, output, 1, SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-014 SHALL have port mosi, output, 1, serial data out, MSB first.
REQ-015 SHALL have port miso, input, 1, serial data in, MSB first.
REQ-016 SHALL have port cs_n, output, 1, active-low chip select.

Function
REQ-017 SHALL decode control register bank[0][7:0] as follows: bit0 send, bit1 all_ones, bit2 all_zeros, bits[7:3] n_end.
- n_end is the index of the last byte; the frame carries n_end+1 bytes.
REQ-018 SHALL implement the states IDLE, CFG, FETCH, SHIFT, WRBACK and CLRCTL.
REQ-019 SHALL move IDLE->CFG on the first clk edge with start=1; start outside IDLE SHALL be ignored.
REQ-020 CFG (1 cycle): SHALL drive hold=1 and addr=0, latch rd_data[7:0] as cfg, and clear idx to 0.
- send=0: SHALL go to IDLE with no writes, no cs_n activity and no done pulse.
- send=1: SHALL go to FETCH.
REQ-021 SHALL clamp n_end to N-1 when n_end > N-1, so data addresses never exceed N.
REQ-022 FETCH (1 cycle): SHALL drive addr=idx+1 and load the tx byte, then go to SHIFT.
- all_ones=1: tx byte SHALL be 8'hFF; all_ones takes priority over all_zeros.
- else all_zeros=1: tx byte SHALL be 8'h00.
- otherwise: tx byte SHALL be rd_data[7:0].
REQ-023 SHIFT SHALL last exactly 16*DIV cycles per byte.
- Phase: sclk low for DIV cycles, then high for DIV cycles, 8 times.
- mosi SHALL hold the current MSB from the start of SHIFT.
- miso SHALL be sampled on the cycle sclk rises; mosi SHALL advance on the cycle sclk falls.
REQ-024 cs_n SHALL fall on entry to the first SHIFT and stay low until CLRCTL is exited; it SHALL stay low between bytes.
REQ-025 WRBACK (1 cycle): SHALL drive wr=1, addr=idx+1 and wr_data=the received byte.
- idx==n_end: SHALL go to CLRCTL.
- otherwise: SHALL increment idx and go to FETCH.
REQ-026 CLRCTL (1 cycle): SHALL drive wr=1, addr=0 and wr_data={cfg[7:1],1'b0}, then go to IDLE.
- cs_n SHALL be 1 from the following cycle.
- done SHALL be 1 during the first IDLE cycle only.
REQ-027 hold SHALL be 1 from CFG through CLRCTL inclusive and 0 in IDLE.
REQ-028 wr SHALL be 0 in every state except WRBACK and CLRCTL.
REQ-029 sclk SHALL be 0 outside SHIFT.
REQ-030 Frame length from the start edge to done SHALL be 1 + (n_end+1)*(16*DIV+2) + 2 cycles.

Reset
REQ-031 On rst=1 at any clk edge, including mid-SHIFT, the block SHALL enter IDLE on the next edge.
- Outputs after reset: cs_n=1, sclk=0, mosi=0, hold=0, wr=0, wr_data=0, addr=0, busy=0, done=0.
- Internal state after reset: shift registers, idx and cfg cleared.
REQ-032 rst SHALL take priority over start in the same cycle.

Verification
REQ-033 Bench SHALL cover the scenarios below, with DIV=2, N=5 and miso looped to mosi unless stated otherwise.
- Two-byte loopback: bank[0]=0x09, bank[1]=0xA5, bank[2]=0x3C, start.
  -> cs_n low 68 cycles; bank[1]=0xA5, bank[2]=0x3C, bank[0]=0x08; done 1 cycle; total 72 cycles.
- Forced zeros: miso=1, bank[0]=0x05.
  -> mosi=0 for all 8 bits; bank[1]=0xFF; bank[0]=0x04.
- Send clear: bank[0]=0x08, start.
  -> CFG then IDLE; cs_n stays 1; no wr; done stays 0.
- Clamp: bank[0]=0xFB (all_ones, n_end=31).
  -> 5 bytes; writes to addresses 1..5 only; mosi all 1s; bank[0]=0xFA.
- Reset mid-frame: rst during bit 3 of byte 0.
  -> next cycle cs_n=1, sclk=0, hold=0, busy=0; a later start runs a full frame correctly.
- Busy start: start pulse issued mid-SHIFT.
  -> ignored; frame timing and contents unchanged; exactly one done pulse.
